// File: rtl/g2_chain_pkg.sv
// ---------------------------------------------------------------------------
// g2_chain_pkg
// Shared definitions for the G2 hash-chain walk controller:
//   - default parameter widths for the controller and its table interface
//   - NULL_INDEX, the all-ones chain terminator
//   - FSM state encoding and the arbiter's last-grant encoding
// ---------------------------------------------------------------------------
package g2_chain_pkg;

   localparam int DEF_INDEX_BIT_LEN    = 11;
   localparam int DEF_PACKET_BIT_LEN   = 104;
   localparam int DEF_ENTRY_DATA_WIDTH = 171;
   localparam int DEF_MAX_HOPS         = 19;

   // Width of the hop counter reported on res_hops.
   localparam int HOPS_W = 5;

   // Chain terminator at the default index width.
   localparam logic [DEF_INDEX_BIT_LEN-1:0] NULL_INDEX = '1;

   // Explicit encodings keep the state values stable for legacy tooling.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_EVAL   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_RESULT = 3'd4
   } state_t;

   typedef enum logic {
      GNT_SRCH = 1'b0,
      GNT_UPD  = 1'b1
   } grant_t;

endpackage

// File: rtl/g2_req_arbiter.sv
// ---------------------------------------------------------------------------
// g2_req_arbiter
// Two-input round-robin arbiter between search and update requests.
// When both requests are present the type not granted last wins. The
// last-grant register resets to "search", so an update wins the first tie.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   i_en         in   arbitration enabled (controller idle)
//   i_req_srch   in   search request pending
//   i_req_upd    in   update request pending
//   o_gnt_srch   out  search granted this cycle
//   o_gnt_upd    out  update granted this cycle
// ---------------------------------------------------------------------------
module g2_req_arbiter
   import g2_chain_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_req_srch,
   input  logic i_req_upd,
   output logic o_gnt_srch,
   output logic o_gnt_upd
);

   grant_t r_last_grant;
   logic   w_upd_first;

   // Updates have priority on a tie only if search was granted last.
   assign w_upd_first = (r_last_grant == GNT_SRCH);

   assign o_gnt_upd  = i_en & i_req_upd  & (~i_req_srch | w_upd_first);
   assign o_gnt_srch = i_en & i_req_srch & (~i_req_upd  | ~w_upd_first);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= GNT_SRCH;
      end else if (o_gnt_upd) begin
         r_last_grant <= GNT_UPD;
      end else if (o_gnt_srch) begin
         r_last_grant <= GNT_SRCH;
      end
   end

endmodule

// File: rtl/g2_chain_ctrl.sv
// ---------------------------------------------------------------------------
// g2_chain_ctrl
// Walks a G2 hash chain in an external registered table. A search starts at
// a head index and probes entries one at a time (LOOKUP presents the index,
// EVAL consumes the registered table outputs) until the tuple matches, the
// chain ends at NULL, or MAX_HOPS entries have been probed. Table writes are
// interleaved with searches by a round-robin arbiter and never overlap a walk.
//
// Ports:
//   clk, rst                 clock / asynchronous active-high reset
//   srch_valid/srch_ready    search request handshake
//   srch_head, srch_tuple    chain head index and 5-tuple key
//   upd_valid/upd_ready      table-write request handshake
//   upd_index, upd_data      write address and entry data
//   res_valid/res_ready      result handshake
//   res_match, res_ruleID    hit flag and matched rule ID (0 on miss)
//   res_hops, res_overflow   entries probed and hop-limit flag
//   tbl_index, tbl_tuple     table address and search key
//   tbl_we, tbl_din          table write enable and write data
//   tbl_match, tbl_ruleID,   registered table outputs, valid one cycle
//   tbl_next_index           after tbl_index is presented
// ---------------------------------------------------------------------------
module g2_chain_ctrl
   import g2_chain_pkg::*;
#(
   parameter int INDEX_BIT_LEN    = DEF_INDEX_BIT_LEN,
   parameter int PACKET_BIT_LEN   = DEF_PACKET_BIT_LEN,
   parameter int ENTRY_DATA_WIDTH = DEF_ENTRY_DATA_WIDTH,
   parameter int MAX_HOPS         = DEF_MAX_HOPS
) (
   input  logic                        clk,
   input  logic                        rst,

   input  logic                        srch_valid,
   output logic                        srch_ready,
   input  logic [INDEX_BIT_LEN-1:0]    srch_head,
   input  logic [PACKET_BIT_LEN-1:0]   srch_tuple,

   input  logic                        upd_valid,
   output logic                        upd_ready,
   input  logic [INDEX_BIT_LEN-1:0]    upd_index,
   input  logic [ENTRY_DATA_WIDTH-1:0] upd_data,

   output logic                        res_valid,
   input  logic                        res_ready,
   output logic                        res_match,
   output logic [INDEX_BIT_LEN-1:0]    res_ruleID,
   output logic [HOPS_W-1:0]           res_hops,
   output logic                        res_overflow,

   output logic [INDEX_BIT_LEN-1:0]    tbl_index,
   output logic [PACKET_BIT_LEN-1:0]   tbl_tuple,
   output logic                        tbl_we,
   output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
   input  logic                        tbl_match,
   input  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID,
   input  logic [INDEX_BIT_LEN-1:0]    tbl_next_index
);

   localparam logic [INDEX_BIT_LEN-1:0] L_NULL     = {INDEX_BIT_LEN{1'b1}};
   localparam logic [HOPS_W-1:0]        L_MAX_HOPS = HOPS_W'(MAX_HOPS);

   state_t                      r_state;
   // r_cur_index doubles as the table address: the walk pointer during a
   // search and the write address during WRITE.
   logic [INDEX_BIT_LEN-1:0]    r_cur_index;
   logic [PACKET_BIT_LEN-1:0]   r_tuple;
   logic [HOPS_W-1:0]           r_hops;
   logic                        r_tbl_we;
   logic [ENTRY_DATA_WIDTH-1:0] r_tbl_din;

   logic                        r_res_valid;
   logic                        r_res_match;
   logic [INDEX_BIT_LEN-1:0]    r_res_ruleID;
   logic [HOPS_W-1:0]           r_res_hops;
   logic                        r_res_overflow;

   logic                        w_idle;
   logic                        w_gnt_srch;
   logic                        w_gnt_upd;

   assign w_idle = (r_state == ST_IDLE);

   g2_req_arbiter u_arb (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_idle),
      .i_req_srch (srch_valid),
      .i_req_upd  (upd_valid),
      .o_gnt_srch (w_gnt_srch),
      .o_gnt_upd  (w_gnt_upd)
   );

   // The readys are combinational, so they are masked by rst to make every
   // output read zero for as long as reset is held.
   assign srch_ready   = w_gnt_srch & ~rst;
   assign upd_ready    = w_gnt_upd  & ~rst;

   assign res_valid    = r_res_valid;
   assign res_match    = r_res_match;
   assign res_ruleID   = r_res_ruleID;
   assign res_hops     = r_res_hops;
   assign res_overflow = r_res_overflow;

   assign tbl_index    = r_cur_index;
   assign tbl_tuple    = r_tuple;
   assign tbl_we       = r_tbl_we;
   assign tbl_din      = r_tbl_din;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_cur_index    <= '0;
         r_tuple        <= '0;
         r_hops         <= '0;
         r_tbl_we       <= 1'b0;
         r_tbl_din      <= '0;
         r_res_valid    <= 1'b0;
         r_res_match    <= 1'b0;
         r_res_ruleID   <= '0;
         r_res_hops     <= '0;
         r_res_overflow <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_upd) begin
                  // Address and data are registered here so WRITE presents
                  // them together with tbl_we for exactly one cycle.
                  r_cur_index <= upd_index;
                  r_tbl_din   <= upd_data;
                  r_tbl_we    <= 1'b1;
                  r_state     <= ST_WRITE;
               end else if (w_gnt_srch) begin
                  r_tuple     <= srch_tuple;
                  r_cur_index <= srch_head;
                  r_hops      <= '0;
                  if (srch_head == L_NULL) begin
                     // Empty chain: report a miss without touching the table.
                     r_res_valid    <= 1'b1;
                     r_res_match    <= 1'b0;
                     r_res_ruleID   <= '0;
                     r_res_hops     <= '0;
                     r_res_overflow <= 1'b0;
                     r_state        <= ST_RESULT;
                  end else begin
                     r_state <= ST_LOOKUP;
                  end
               end
            end

            ST_LOOKUP: begin
               // tbl_index/tbl_tuple are already on the table; the registered
               // response arrives in EVAL.
               r_hops  <= r_hops + 1'b1;
               r_state <= ST_EVAL;
            end

            ST_EVAL: begin
               if (tbl_match) begin
                  r_res_valid    <= 1'b1;
                  r_res_match    <= 1'b1;
                  r_res_ruleID   <= tbl_ruleID;
                  r_res_hops     <= r_hops;
                  r_res_overflow <= 1'b0;
                  r_state        <= ST_RESULT;
               end else if (tbl_next_index == L_NULL) begin
                  r_res_valid    <= 1'b1;
                  r_res_match    <= 1'b0;
                  r_res_ruleID   <= '0;
                  r_res_hops     <= r_hops;
                  r_res_overflow <= 1'b0;
                  r_state        <= ST_RESULT;
               end else if (r_hops == L_MAX_HOPS) begin
                  // Guards against cyclic or over-long chains.
                  r_res_valid    <= 1'b1;
                  r_res_match    <= 1'b0;
                  r_res_ruleID   <= '0;
                  r_res_hops     <= r_hops;
                  r_res_overflow <= 1'b1;
                  r_state        <= ST_RESULT;
               end else begin
                  r_cur_index <= tbl_next_index;
                  r_state     <= ST_LOOKUP;
               end
            end

            ST_WRITE: begin
               r_tbl_we <= 1'b0;
               r_state  <= ST_IDLE;
            end

            ST_RESULT: begin
               if (res_ready) begin
                  r_res_valid    <= 1'b0;
                  r_res_match    <= 1'b0;
                  r_res_ruleID   <= '0;
                  r_res_hops     <= '0;
                  r_res_overflow <= 1'b0;
                  r_state        <= ST_IDLE;
               end
            end

            default: begin
               r_tbl_we <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_g2_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_g2_chain_ctrl
// Bench for g2_chain_ctrl. A registered table model sits on the tbl_* port;
// entries are written only through the DUT's update path. Expected search
// results come from a chain-walk reference over a bench-side copy of the
// table contents. Entry layout used by the table model:
//   [2*IW +: PW] key tuple, [IW +: IW] rule ID, [0 +: IW] next index.
// ---------------------------------------------------------------------------
module tb_g2_chain_ctrl;
   import g2_chain_pkg::*;

   localparam int IW = 11;
   localparam int PW = 104;
   localparam int EW = 171;
   localparam int MH = 19;

   logic          clk = 1'b0;
   logic          rst;
   logic          srch_valid, srch_ready;
   logic [IW-1:0] srch_head;
   logic [PW-1:0] srch_tuple;
   logic          upd_valid, upd_ready;
   logic [IW-1:0] upd_index;
   logic [EW-1:0] upd_data;
   logic          res_valid, res_ready, res_match, res_overflow;
   logic [IW-1:0] res_ruleID;
   logic [4:0]    res_hops;
   logic [IW-1:0] tbl_index;
   logic [PW-1:0] tbl_tuple;
   logic          tbl_we;
   logic [EW-1:0] tbl_din;
   logic          tbl_match;
   logic [IW-1:0] tbl_ruleID, tbl_next_index;

   int checks = 0;
   int errors = 0;
   int walk_we = 0;
   logic in_walk = 1'b0;

   logic [EW-1:0] tb_mem  [0:(1<<IW)-1];
   logic [PW-1:0] ref_key [0:(1<<IW)-1];
   logic [IW-1:0] ref_rule[0:(1<<IW)-1];
   logic [IW-1:0] ref_next[0:(1<<IW)-1];

   logic          last_m, last_o;
   logic [IW-1:0] last_r;
   logic [4:0]    last_h;
   int            last_lat;

   always #5 clk = ~clk;

   g2_chain_ctrl #(
      .INDEX_BIT_LEN(IW), .PACKET_BIT_LEN(PW),
      .ENTRY_DATA_WIDTH(EW), .MAX_HOPS(MH)
   ) dut (
      .clk(clk), .rst(rst),
      .srch_valid(srch_valid), .srch_ready(srch_ready),
      .srch_head(srch_head), .srch_tuple(srch_tuple),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_index(upd_index), .upd_data(upd_data),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_match(res_match), .res_ruleID(res_ruleID),
      .res_hops(res_hops), .res_overflow(res_overflow),
      .tbl_index(tbl_index), .tbl_tuple(tbl_tuple),
      .tbl_we(tbl_we), .tbl_din(tbl_din),
      .tbl_match(tbl_match), .tbl_ruleID(tbl_ruleID),
      .tbl_next_index(tbl_next_index)
   );

   // Registered G2 table model.
   always @(posedge clk) begin
      if (tbl_we) tb_mem[tbl_index] <= tbl_din;
      tbl_match      <= (tb_mem[tbl_index][2*IW +: PW] == tbl_tuple);
      tbl_ruleID     <= tb_mem[tbl_index][IW +: IW];
      tbl_next_index <= tb_mem[tbl_index][0 +: IW];
   end

   // No table write may appear while a search is in flight.
   always @(posedge clk) begin
      if (in_walk && tbl_we) walk_we <= walk_we + 1;
   end

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk_entry(input logic [PW-1:0] key,
                                              input logic [IW-1:0] rule,
                                              input logic [IW-1:0] nxt);
      logic [EW-1:0] e;
      e = '0;
      e[2*IW +: PW] = key;
      e[IW +: IW]   = rule;
      e[0 +: IW]    = nxt;
      return e;
   endfunction

   // Reference walk: probe entries from head until key match, NULL next, or
   // the hop limit; a walk of h probes takes 2*h+1 cycles from accept.
   task automatic ref_walk(input logic [IW-1:0] head, input logic [PW-1:0] tup,
                           output logic m, output logic [IW-1:0] r,
                           output logic [4:0] h, output logic o, output int lat);
      logic [IW-1:0] idx;
      int hc;
      idx = head; hc = 0; m = 1'b0; r = '0; o = 1'b0;
      if (head != NULL_INDEX) begin
         for (int k = 1; k <= MH; k++) begin
            hc = k;
            if (ref_key[idx] == tup) begin m = 1'b1; r = ref_rule[idx]; break; end
            if (ref_next[idx] == NULL_INDEX) break;
            if (k == MH) begin o = 1'b1; break; end
            idx = ref_next[idx];
         end
      end
      h   = hc[4:0];
      lat = 2 * hc + 1;
   endtask

   task automatic set_ref(input logic [IW-1:0] idx, input logic [PW-1:0] key,
                          input logic [IW-1:0] rule, input logic [IW-1:0] nxt);
      ref_key[idx] = key; ref_rule[idx] = rule; ref_next[idx] = nxt;
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {srch_ready, upd_ready, res_valid, res_match, res_ruleID, res_hops,
                res_overflow, tbl_index, tbl_we, tbl_tuple[63:0]}, '0);
      chk({tag, "_hi"}, {tbl_tuple[PW-1:64], tbl_din[EW-1:128]}, '0);
      chk({tag, "_din"}, {64'd0, tbl_din[127:0]}, '0);
   endtask

   // Called at #1 after an edge with the DUT idle.
   task automatic do_update(input logic [IW-1:0] idx, input logic [PW-1:0] key,
                            input logic [IW-1:0] rule, input logic [IW-1:0] nxt);
      logic [EW-1:0] d;
      int n;
      d = mk_entry(key, rule, nxt);
      upd_valid = 1'b1; upd_index = idx; upd_data = d;
      #1;
      n = 0;
      while (!upd_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("upd_ready", upd_ready, 1'b1);
      @(posedge clk); #1;
      upd_valid = 1'b0;
      chk("wr_we", tbl_we, 1'b1);
      chk("wr_index", tbl_index, idx);
      chk("wr_din", tbl_din, d);
      @(posedge clk); #1;
      chk("wr_we_off", tbl_we, 1'b0);
      chk("wr_din_hold", tbl_din, d);
      set_ref(idx, key, rule, nxt);
   endtask

   // Called at #1 after an edge with the DUT idle.
   task automatic do_search(input logic [IW-1:0] head, input logic [PW-1:0] tup,
                            input int stall);
      logic em, eo;
      logic [IW-1:0] er;
      logic [4:0] eh;
      int elat, n, lat;
      logic [IW+7:0] snap;
      ref_walk(head, tup, em, er, eh, eo, elat);
      srch_valid = 1'b1; srch_head = head; srch_tuple = tup;
      #1;
      n = 0;
      while (!srch_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("srch_ready", srch_ready, 1'b1);
      @(posedge clk); #1;
      srch_valid = 1'b0;
      in_walk = 1'b1;
      lat = 1;
      while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("res_latency", lat, elat);
      chk("res_match", res_match, em);
      chk("res_ruleID", res_ruleID, er);
      chk("res_hops", res_hops, eh);
      chk("res_overflow", res_overflow, eo);
      last_m = res_match; last_r = res_ruleID; last_h = res_hops;
      last_o = res_overflow; last_lat = lat;
      snap = {res_match, res_ruleID, res_hops, res_overflow, res_valid};
      if (stall > 0) begin
         srch_valid = 1'b1; upd_valid = 1'b1;
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_readys", {srch_ready, upd_ready}, 2'b00);
            chk("stall_res", {res_match, res_ruleID, res_hops, res_overflow, res_valid}, snap);
         end
         srch_valid = 1'b0; upd_valid = 1'b0;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      in_walk = 1'b0;
      chk("res_released", res_valid, 1'b0);
   endtask

   logic [PW-1:0] KA, KB, KC, KD;
   logic [PW-1:0] kp [4];
   logic [PW-1:0] rt;
   int seen_rv, seen_we, n;

   initial begin
      KA = {8'hA1, 96'h0123_4567_89AB_CDEF_0011_2233};
      KB = {8'hB2, 96'h1111_2222_3333_4444_5555_6666};
      KC = {8'hC3, 96'h7777_8888_9999_AAAA_BBBB_CCCC};
      KD = {8'hD4, 96'hDEAD_BEEF_CAFE_F00D_1234_5678};
      for (int i = 0; i < 4; i++) kp[i] = {8'h5A, $urandom, $urandom, $urandom};

      rst = 1'b1; res_ready = 1'b0;
      srch_valid = 1'b1; upd_valid = 1'b1;
      srch_head = '0; srch_tuple = '0; upd_index = '0; upd_data = '0;
      #12;
      chk_all_zero("reset_state");
      srch_valid = 1'b0; upd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Head hit, rule 5.
      do_update(11'd10, KA, 11'd5, NULL_INDEX);
      do_search(11'd10, KA, 0);
      chk("hit_lat3", last_lat, 3);
      chk("hit_rule5", {last_m, last_r, last_h, last_o}, {1'b1, 11'd5, 5'd1, 1'b0});

      // Chain 3->7->NULL, no match, with a 5-cycle result stall.
      do_update(11'd3, KB, 11'd9, 11'd7);
      do_update(11'd7, KC, 11'd4, NULL_INDEX);
      do_search(11'd3, KD, 5);
      chk("miss_chain", {last_m, last_r, last_h, last_o}, {1'b0, 11'd0, 5'd2, 1'b0});
      do_search(11'd3, KC, 0);

      // Cyclic chain 1->2->1 hits the hop limit.
      do_update(11'd1, KB, 11'd1, 11'd2);
      do_update(11'd2, KC, 11'd2, 11'd1);
      do_search(11'd1, KA, 0);
      chk("cyclic_ovf", {last_m, last_r, last_h, last_o}, {1'b0, 11'd0, 5'd19, 1'b1});

      // NULL head returns a miss directly.
      do_search(NULL_INDEX, KA, 0);
      chk("null_head", {last_m, last_h, last_o}, {1'b0, 5'd0, 1'b0});

      // Reset while in EVAL.
      srch_valid = 1'b1; srch_head = 11'd1; srch_tuple = KA;
      @(posedge clk); #1;
      srch_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk_all_zero("rst_eval");
      @(posedge clk); #1;
      rst = 1'b0;
      seen_rv = 0; seen_we = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (res_valid) seen_rv++;
         if (tbl_we) seen_we++;
      end
      chk("rst_no_result", seen_rv, 0);
      chk("rst_no_write", seen_we, 0);

      // Both requests held: update, search, update.
      upd_valid = 1'b1; upd_index = 11'd20; upd_data = mk_entry(KB, 11'd20, NULL_INDEX);
      srch_valid = 1'b1; srch_head = 11'd10; srch_tuple = KA;
      #1;
      chk("alt_first_upd", {upd_ready, srch_ready}, 2'b10);
      @(posedge clk); #1;
      chk("alt_we1", {tbl_we, tbl_index}, {1'b1, 11'd20});
      set_ref(11'd20, KB, 11'd20, NULL_INDEX);
      upd_index = 11'd21; upd_data = mk_entry(KC, 11'd21, NULL_INDEX);
      @(posedge clk); #1;
      chk("alt_we1_pulse", tbl_we, 1'b0);
      chk("alt_then_srch", {upd_ready, srch_ready}, 2'b01);
      @(posedge clk); #1;
      n = 1;
      while (!res_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("alt_srch_lat", n, 3);
      chk("alt_srch_res", {res_match, res_ruleID}, {1'b1, 11'd5});
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("alt_then_upd", {upd_ready, srch_ready}, 2'b10);
      srch_valid = 1'b0;
      @(posedge clk); #1;
      upd_valid = 1'b0;
      chk("alt_we2", {tbl_we, tbl_index}, {1'b1, 11'd21});
      set_ref(11'd21, KC, 11'd21, NULL_INDEX);
      @(posedge clk); #1;
      chk("alt_we2_pulse", tbl_we, 1'b0);

      // Randomized chains over indices 16..23.
      for (int i = 16; i < 24; i++)
         do_update(i[IW-1:0], kp[$urandom % 4], IW'($urandom % 2047),
                   ($urandom % 4 == 0) ? NULL_INDEX : IW'(16 + $urandom % 8));
      for (int t = 0; t < 20; t++) begin
         if ($urandom % 4 == 0) begin
            do_update(IW'(16 + $urandom % 8), kp[$urandom % 4], IW'($urandom % 2047),
                      ($urandom % 3 == 0) ? NULL_INDEX : IW'(16 + $urandom % 8));
         end
         rt = ($urandom % 3 == 0) ? {8'h3C, $urandom, $urandom, $urandom} : kp[$urandom % 4];
         do_search(($urandom % 8 == 0) ? NULL_INDEX : IW'(16 + $urandom % 8), rt,
                   int'($urandom % 3));
      end

      chk("walk_no_write", walk_we, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
